// File: rtl/mcp4725_pkg.sv
// mcp4725_pkg: shared widths, sequencer states and saturating increment for the MCP4725 sample sequencer
package mcp4725_pkg;
  localparam int DAC_W = 12;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} seq_state_e;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return v == '1 ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/mcp4725_sample_fifo.sv
// mcp4725_sample_fifo: synchronous power-of-2 sample FIFO with occupancy output
module mcp4725_sample_fifo
  import mcp4725_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DAC_W-1:0]         din,
  input  logic                     pop,
  output logic [DAC_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DAC_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/mcp4725_sample_sequencer.sv
// mcp4725_sample_sequencer: paces buffered DAC samples into one writer request per sample tick; MCP_SEQ_RETRY_EN adds NACK retry
module mcp4725_sample_sequencer
  import mcp4725_pkg::*;
#(
  parameter int SYS_CLK_HZ = 12_000_000,
  parameter int SAMPLE_HZ  = 1_000,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RETRY  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DAC_W-1:0]              s_data,
  output logic                          wr_start,
  output logic [DAC_W-1:0]              wr_code,
  input  logic                          wr_busy,
  input  logic                          wr_done,
  input  logic                          wr_nack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              underrun_cnt,
  output logic [CNT_W-1:0]              late_cnt,
  output logic [CNT_W-1:0]              nack_cnt
);
  localparam int DIV = SYS_CLK_HZ / SAMPLE_HZ;
  localparam int TW = $clog2(DIV);
  seq_state_e state_q, state_d;
  logic [TW-1:0] tcnt;
  logic [DAC_W-1:0] head;
  logic tick, pop, full, empty, retry, unused_busy;
  assign unused_busy = wr_busy;
  assign tick = enable && tcnt == TW'(DIV - 1);
  assign s_ready = !full;
  mcp4725_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .din   (s_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
`ifdef MCP_SEQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;
  assign retry = state_q == S_WAIT_DONE && wr_done && wr_nack && retry_cnt < RW'(MAX_RETRY);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retry_cnt <= '0;
    else if (pop) retry_cnt <= '0;
    else if (retry) retry_cnt <= retry_cnt + RW'(1);
`else
  localparam int UNUSED_MAX_RETRY = MAX_RETRY;
  assign retry = 1'b0;
`endif
  always_comb begin
    pop = 1'b0;
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        pop = tick && !empty;
        state_d = pop ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: state_d = !wr_done ? S_WAIT_DONE : retry ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      tcnt <= '0;
      wr_start <= 1'b0;
      wr_code <= '0;
      underrun_cnt <= '0;
      late_cnt <= '0;
      nack_cnt <= '0;
    end else begin
      state_q <= state_d;
      tcnt <= !enable || tick ? '0 : tcnt + TW'(1);
      wr_start <= state_q == S_ISSUE;
      if (pop) wr_code <= head;
      if (tick && state_q == S_IDLE && empty) underrun_cnt <= sat_inc(underrun_cnt);
      if (tick && state_q != S_IDLE) late_cnt <= sat_inc(late_cnt);
      if (state_q == S_WAIT_DONE && wr_done && wr_nack) nack_cnt <= sat_inc(nack_cnt);
    end
endmodule

// File: tb/tb_mcp4725_sample_sequencer.sv
// tb_mcp4725_sample_sequencer: randomized bench with an event-level reference model of the sample sequencer
module tb_mcp4725_sample_sequencer;
  localparam int DIV = 10, DEPTH = 4, MAXR = 2;
`ifdef MCP_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  logic clk = 0, rst_n = 0, enable = 0, s_valid = 0, wr_busy = 0, wr_done = 0, wr_nack = 0;
  logic [11:0] s_data = '0;
  logic s_ready, wr_start;
  logic [11:0] wr_code;
  logic [2:0] fifo_level;
  logic [15:0] underrun_cnt, late_cnt, nack_cnt;
  always #5 clk = ~clk;
  mcp4725_sample_sequencer #(
    .SYS_CLK_HZ(1000), .SAMPLE_HZ(100), .FIFO_DEPTH(DEPTH), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .wr_start(wr_start), .wr_code(wr_code), .wr_busy(wr_busy),
    .wr_done(wr_done), .wr_nack(wr_nack), .fifo_level(fifo_level),
    .underrun_cnt(underrun_cnt), .late_cnt(late_cnt), .nack_cnt(nack_cnt)
  );
  int n_checks = 0, n_pass = 0;
  logic [11:0] q[$];
  logic [11:0] starts[$];
  logic [11:0] m_code;
  int run, cyc = 0, start_at, retries, m_under, m_late, m_nack;
  int wd, done_lat = 5, nack_pct = 0;
  bit inflight, pushed = 0, nack_abc = 0, nack_rand = 0, w_nack = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    q.delete();
    run = 0; inflight = 0; start_at = -1; retries = 0; m_code = '0;
    m_under = 0; m_late = 0; m_nack = 0; wd = 0; pushed = 0;
    wr_done = 0; wr_nack = 0; wr_busy = 0;
  endtask
  task automatic check_idle_outputs(input string t);
    check({t, "_wr_start"}, 32'(wr_start), 32'd0);
    check({t, "_wr_code"}, 32'(wr_code), 32'd0);
    check({t, "_fifo_level"}, 32'(fifo_level), 32'd0);
    check({t, "_s_ready"}, 32'(s_ready), 32'd1);
    check({t, "_underrun"}, 32'(underrun_cnt), 32'd0);
    check({t, "_late"}, 32'(late_cnt), 32'd0);
    check({t, "_nack"}, 32'(nack_cnt), 32'd0);
  endtask
  task automatic step();
    bit tick, ready;
    wr_done = 0;
    wr_nack = 0;
    if (wd > 0) begin
      wd--;
      wr_done = wd == 0;
      wr_nack = wr_done && w_nack;
    end
    wr_busy = wd > 0;
    tick = enable && run % DIV == DIV - 1;
    run = enable ? run + 1 : 0;
    ready = q.size() < DEPTH;
    if (tick && inflight) m_late++;
    else if (tick && q.size() == 0) m_under++;
    else if (tick) begin
      m_code = q.pop_front();
      inflight = 1;
      start_at = cyc + 2;
      retries = 0;
    end
    if (wr_done && inflight && cyc >= start_at) begin
      if (wr_nack) m_nack++;
      if (wr_nack && RETRY && retries < MAXR) begin
        retries++;
        start_at = cyc + 2;
      end else inflight = 0;
    end
    pushed = s_valid && ready;
    if (pushed) q.push_back(s_data);
    @(posedge clk);
    #1;
    cyc++;
    if (wr_start) begin
      starts.push_back(wr_code);
      w_nack = (nack_abc && wr_code == 12'hABC) || (nack_rand && $urandom_range(99) < nack_pct);
      wd = done_lat;
    end
    check("wr_start", 32'(wr_start), 32'(cyc == start_at));
    check("wr_code", 32'(wr_code), 32'(m_code));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
    check("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
    check("late_cnt", 32'(late_cnt), 32'(m_late));
    check("nack_cnt", 32'(nack_cnt), 32'(m_nack));
  endtask
  function automatic int count_code(input int from, input logic [11:0] c);
    int n = 0;
    for (int i = from; i < starts.size(); i++) if (starts[i] == c) n++;
    return n;
  endfunction
  initial begin
    int idx, base;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1;
    s_valid = 1; s_data = 12'h123; step();
    s_data = 12'h456; step();
    s_valid = 0;
    enable = 1;
    repeat (25) step();
    check("t1_starts", 32'(starts.size()), 32'd2);
    check("t1_first", 32'(starts.size() > 0 ? starts[0] : 12'hFFF), 32'h123);
    check("t1_second", 32'(starts.size() > 1 ? starts[1] : 12'hFFF), 32'h456);
    base = m_under;
    repeat (30) step();
    check("t2_underrun", 32'(underrun_cnt), 32'(base + 3));
    check("t2_no_start", 32'(starts.size()), 32'd2);
    check("t2_code_hold", 32'(wr_code), 32'h456);
    done_lat = 15;
    base = m_late;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = 12'h300 + 12'(k); step();
    end
    s_valid = 0;
    repeat (62) step();
    check("t3_late", 32'(late_cnt), 32'(base + 3));
    check("t3_starts", 32'(starts.size()), 32'd5);
    done_lat = 5;
    enable = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      s_valid = 1; s_data = 12'h200 + 12'(k); step();
    end
    check("t4_level_full", 32'(fifo_level), 32'd4);
    check("t4_ready_full", 32'(s_ready), 32'd0);
    s_data = 12'h204;
    step();
    step();
    check("t4_fifth_stalled", 32'(pushed), 32'd0);
    enable = 1;
    for (int k = 0; k < 30 && !pushed; k++) step();
    check("t4_fifth_accepted", 32'(pushed), 32'd1);
    check("t4_level_refill", 32'(fifo_level), 32'd4);
    s_valid = 0;
    repeat (55) step();
    check("t4_drained", 32'(fifo_level), 32'd0);
    nack_abc = 1;
    idx = starts.size();
    base = m_nack;
    s_valid = 1; s_data = 12'hABC; step();
    s_data = 12'h111; step();
    s_valid = 0;
    repeat (60) step();
    check("t5_abc_starts", 32'(count_code(idx, 12'hABC)), RETRY ? 32'd3 : 32'd1);
    check("t5_nack_cnt", 32'(nack_cnt), 32'(base + (RETRY ? 3 : 1)));
    check("t5_next_issued", 32'(count_code(idx, 12'h111)), 32'd1);
    nack_abc = 0;
    nack_rand = 1;
    nack_pct = 30;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) enable = !enable;
      if (pushed || !s_valid) begin
        s_valid = 1'($urandom_range(1));
        s_data = 12'($urandom);
      end
      done_lat = $urandom_range(18, 1);
      step();
    end
    nack_rand = 0;
    enable = 1;
    done_lat = 8;
    s_valid = 1; s_data = 12'h5A5; step();
    s_valid = 0;
    for (int k = 0; k < 60 && !(inflight && cyc > start_at); k++) step();
    #2;
    rst_n = 0;
    #1;
    check_idle_outputs("t7_async");
    model_reset();
    @(posedge clk);
    #1;
    check_idle_outputs("t7_held");
    rst_n = 1;
    idx = starts.size();
    s_valid = 1; s_data = 12'h777; step();
    s_valid = 0;
    repeat (20) step();
    check("t7_post_reset_start", 32'(count_code(idx, 12'h777)), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
